// File: rtl/bignum_tx_pkg.sv
// Shared types and constants for the bignum TX scheduler.
package bignum_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        SETTLE,
        SEND,
        DONE
    } state_e;

    localparam logic [7:0] HEADER_TAG = 8'hA0;

    // Header byte announcing which producer owns the following number
    function automatic logic [7:0] header_byte(input logic [3:0] id);
        return HEADER_TAG | {4'h0, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned N    = 2,
    parameter int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_grant,
    output logic [ID_W-1:0] o_id,
    output logic            o_any
);

    // Walk the requesters starting at the pointer and keep the first hit
    always_comb begin
        logic [ID_W-1:0] idx;
        logic            found;
        o_grant = '0;
        o_id    = '0;
        found   = 1'b0;
        idx     = i_ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && i_req[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                o_id         = idx;
            end
            idx = (idx == ID_W'(N - 1)) ? '0 : idx + 1'b1;
        end
        o_any = found;
    end

endmodule

// File: rtl/bignum_tx_scheduler.sv
// Shares one byte repeater and one UART TX between several producers of large numbers.
// Each granted number is loaded word-wise into the repeater, then sent as a header byte
// followed by the number's bytes, LSB first.
module bignum_tx_scheduler
    import bignum_tx_pkg::*;
#(
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned BITS_IN_NUM   = 4096,
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [NUM_REQ-1:0]               req_in,
    output logic [NUM_REQ-1:0]               grant_out,
    input  logic [NUM_REQ*REGISTER_SIZE-1:0] data_in,
    input  logic [NUM_REQ-1:0]               valid_in,
    output logic [REGISTER_SIZE-1:0]         rep_data_out,
    output logic                             rep_valid_out,
    output logic                             rep_request_next_out,
    input  logic [7:0]                       rep_byte_in,
    input  logic                             rep_byte_valid_in,
    output logic [7:0]                       uart_data_out,
    output logic                             uart_trigger_out,
    input  logic                             uart_busy_in,
    output logic                             busy_out,
    output logic                             done_out
);

    localparam int unsigned NUM_WORDS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int unsigned NUM_BYTES = BITS_IN_NUM / 8;
    localparam int unsigned CNT_W     = $clog2(NUM_BYTES + 1);
    localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SET_W     = $clog2(SETTLE_CYCLES + 2);

    state_e               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [ID_W-1:0]      r_id;
    logic [ID_W-1:0]      r_rr;
    logic [CNT_W-1:0]     r_word_cnt;
    logic [CNT_W-1:0]     r_byte_cnt;
    logic [SET_W-1:0]     r_settle;
    logic [7:0]           r_uart_data;
    logic                 r_uart_trig;
    logic                 r_rep_req;
    logic                 r_done;

    logic [NUM_REQ-1:0]       w_grant;
    logic [ID_W-1:0]          w_id;
    logic                     w_any;
    logic [REGISTER_SIZE-1:0] w_word;
    logic                     w_valid;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_req   (req_in),
        .i_ptr   (r_rr),
        .o_grant (w_grant),
        .o_id    (w_id),
        .o_any   (w_any)
    );

    // Forward only the granted producer's word; everything else is ignored
    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_word = data_in[i*REGISTER_SIZE +: REGISTER_SIZE];
            end
        end
        w_valid = (r_state == LOAD) && ((valid_in & r_grant) != '0);
    end

    assign rep_data_out         = (r_state == LOAD) ? w_word : '0;
    assign rep_valid_out        = w_valid;
    assign rep_request_next_out = r_rep_req;
    assign grant_out            = r_grant;
    assign uart_data_out        = r_uart_data;
    assign uart_trigger_out     = r_uart_trig;
    assign busy_out             = (r_state != IDLE);
    assign done_out             = r_done;

    // Scheduler FSM with counters and registered pulse outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_id        <= '0;
            r_rr        <= '0;
            r_word_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_settle    <= '0;
            r_uart_data <= '0;
            r_uart_trig <= 1'b0;
            r_rep_req   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_uart_trig <= 1'b0;
            r_rep_req   <= 1'b0;
            r_done      <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_grant;
                        r_id    <= w_id;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_valid) begin
                        if (r_word_cnt == CNT_W'(NUM_WORDS - 1)) begin
                            r_word_cnt <= '0;
                            r_state    <= HEADER;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (!uart_busy_in) begin
                        r_uart_data <= header_byte(4'(r_id));
                        r_uart_trig <= 1'b1;
                        r_settle    <= SET_W'(SETTLE_CYCLES);
                        r_state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Busy lags the trigger, so it is only trusted once the settle count expires
                    if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end else if (!uart_busy_in) begin
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (rep_byte_valid_in && !uart_busy_in) begin
                        r_uart_data <= rep_byte_in;
                        r_uart_trig <= 1'b1;
                        r_rep_req   <= 1'b1;
                        if (r_byte_cnt == CNT_W'(NUM_BYTES - 1)) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_settle   <= SET_W'(SETTLE_CYCLES);
                            r_state    <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    r_grant    <= '0;
                    r_rr       <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
                    r_word_cnt <= '0;
                    r_byte_cnt <= '0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bignum_tx_scheduler.sv
// Randomized bench for bignum_tx_scheduler with repeater and UART behavioural models.
module tb_bignum_tx_scheduler;

    localparam int NREQ = 2;
    localparam int BITS = 128;
    localparam int NW   = BITS / 32;
    localparam int NB   = BITS / 8;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic [NREQ-1:0]      req_in;
    logic [NREQ-1:0]      grant_out;
    logic [NREQ*32-1:0]   data_in;
    logic [NREQ-1:0]      valid_in;
    logic [31:0]          rep_data_out;
    logic                 rep_valid_out;
    logic                 rep_request_next_out;
    logic [7:0]           rep_byte_in;
    logic                 rep_byte_valid_in;
    logic [7:0]           uart_data_out;
    logic                 uart_trigger_out;
    logic                 uart_busy_in;
    logic                 busy_out;
    logic                 done_out;

    always #5 clk_in = ~clk_in;

    bignum_tx_scheduler #(
        .REGISTER_SIZE (32),
        .BITS_IN_NUM   (BITS),
        .NUM_REQ       (NREQ),
        .SETTLE_CYCLES (3)
    ) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .req_in               (req_in),
        .grant_out            (grant_out),
        .data_in              (data_in),
        .valid_in             (valid_in),
        .rep_data_out         (rep_data_out),
        .rep_valid_out        (rep_valid_out),
        .rep_request_next_out (rep_request_next_out),
        .rep_byte_in          (rep_byte_in),
        .rep_byte_valid_in    (rep_byte_valid_in),
        .uart_data_out        (uart_data_out),
        .uart_trigger_out     (uart_trigger_out),
        .uart_busy_in         (uart_busy_in),
        .busy_out             (busy_out),
        .done_out             (done_out)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]      num [NREQ][NB];
    int              pidx [NREQ];
    logic [NREQ-1:0] has_num;
    logic [7:0]      exp_q [$];
    logic [7:0]      rq [$];
    int              gq [$];
    int              lat, busy_cnt, busy_len, ptr_m, cur_id, done_cnt, rx_cnt;
    logic [NREQ-1:0] prev_grant, req_drv_prev;
    logic            busy_drv_prev;
    bit              refill, rand_arrive, rand_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input int i, input int w);
        return {num[i][4*w+3], num[i][4*w+2], num[i][4*w+1], num[i][4*w]};
    endfunction

    // Spec rule: first requester at or after the pointer, wrapping
    function automatic int ref_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return NREQ;
    endfunction

    task automatic new_number(input int i);
        for (int b = 0; b < NB; b++) num[i][b] = 8'($urandom);
        pidx[i] = 0;
    endtask

    // One clock: observe DUT outputs at the falling edge, then drive the next inputs
    task automatic step();
        @(negedge clk_in);
        check("grant_onehot", 32'($countones(grant_out) <= 1), 32'd1);
        if (grant_out != '0 && prev_grant == '0) begin
            check("grant_pick", 32'(grant_out), 32'(1) << ref_pick(req_drv_prev, ptr_m));
            for (int i = 0; i < NREQ; i++) if (grant_out[i]) cur_id = i;
            gq.push_back(cur_id);
            exp_q.push_back(8'hA0 | 8'(cur_id));
            for (int b = 0; b < NB; b++) exp_q.push_back(num[cur_id][b]);
            rx_cnt = 0;
        end
        prev_grant = grant_out;
        if (uart_trigger_out) begin
            check("trig_while_busy", 32'(busy_drv_prev), 32'd0);
            if (exp_q.size() == 0) check("uart_unexpected", 32'(uart_trigger_out), 32'd0);
            else check("uart_byte", 32'(uart_data_out), 32'(exp_q.pop_front()));
            rx_cnt++;
            busy_cnt = rand_busy ? int'($urandom_range(0, 8)) : busy_len;
        end
        if (done_out) begin
            check("done_with_trig", 32'(uart_trigger_out), 32'd1);
            check("done_drained", 32'(exp_q.size()), 32'd0);
            done_cnt++;
            ptr_m = (cur_id + 1) % NREQ;
            new_number(cur_id);
            has_num[cur_id] = refill ? 1'b1 : (rand_arrive ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        if (rep_request_next_out) begin
            check("rep_pop_nonempty", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) void'(rq.pop_front());
            lat = 2;
        end else if (lat > 0) begin
            lat--;
        end

        for (int i = 0; i < NREQ; i++) begin
            if (rand_arrive && !has_num[i] && !grant_out[i] && $urandom_range(0, 7) == 0)
                has_num[i] = 1'b1;
            req_in[i] = has_num[i] && !(grant_out[i] && $urandom_range(0, 3) == 0);
            if (grant_out[i] && pidx[i] < NW && $urandom_range(0, 3) != 0) begin
                valid_in[i]        = 1'b1;
                data_in[i*32 +: 32] = word(i, pidx[i]);
            end else begin
                valid_in[i]        = !grant_out[i] && ($urandom_range(0, 1) == 1);
                data_in[i*32 +: 32] = $urandom;
            end
        end
        uart_busy_in = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        req_drv_prev  = req_in;
        busy_drv_prev = uart_busy_in;
        #1;
        if (rep_valid_out) begin
            check("rep_valid_src", 32'(|(valid_in & grant_out)), 32'd1);
            if (pidx[cur_id] < NW) begin
                check("rep_word", rep_data_out, word(cur_id, pidx[cur_id]));
                for (int b = 0; b < 4; b++) rq.push_back(num[cur_id][4*pidx[cur_id]+b]);
                pidx[cur_id]++;
            end else begin
                check("rep_extra_word", 32'(rep_valid_out), 32'd0);
            end
        end
        rep_byte_valid_in = (rq.size() != 0) && (lat == 0);
        rep_byte_in       = (rq.size() != 0) ? rq[0] : 8'h00;
    endtask

    // Synchronous reset across one rising edge; the repeater model restarts empty too
    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        req_in = '0;
        valid_in = '0;
        uart_busy_in = 1'b0;
        rep_byte_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("rst_grant", 32'(grant_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_trig", 32'(uart_trigger_out), 32'd0);
        check("rst_udata", 32'(uart_data_out), 32'd0);
        check("rst_rvalid", 32'(rep_valid_out), 32'd0);
        check("rst_rnext", 32'(rep_request_next_out), 32'd0);
        check("rst_rdata", rep_data_out, 32'd0);
        exp_q.delete();
        rq.delete();
        lat = 0; busy_cnt = 0; ptr_m = 0; rx_cnt = 0;
        prev_grant = '0; req_drv_prev = '0; busy_drv_prev = 1'b0;
        has_num = '0;
        for (int i = 0; i < NREQ; i++) new_number(i);
        rst_in = 1'b0;
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(done_cnt), 32'(target));
    endtask

    initial begin
        int dc;
        int n;
        rst_in = 1'b1; req_in = '0; valid_in = '0; data_in = '0;
        rep_byte_in = '0; rep_byte_valid_in = 1'b0; uart_busy_in = 1'b0;
        lat = 0; busy_cnt = 0; busy_len = 0; ptr_m = 0; cur_id = 0; done_cnt = 0; rx_cnt = 0;
        prev_grant = '0; req_drv_prev = '0; busy_drv_prev = 1'b0; has_num = '0;
        refill = 0; rand_arrive = 0; rand_busy = 0;
        repeat (3) @(posedge clk_in);
        do_reset();

        // No requests: stays idle
        for (int c = 0; c < 20; c++) begin
            step();
            check("idle_busy", 32'(busy_out), 32'd0);
        end

        // Fixed pattern from producer 0: A0, 00..0F, one done
        for (int b = 0; b < NB; b++) num[0][b] = 8'(b);
        pidx[0] = 0;
        has_num = 2'b01;
        run_until(1, 2000, "s3_done");
        repeat (30) step();
        check("s3_done_once", 32'(done_cnt), 32'd1);

        // Both requesting: alternate 0,1,0,1
        do_reset();
        gq.delete();
        refill = 1;
        has_num = 2'b11;
        dc = done_cnt;
        run_until(dc + 4, 4000, "s4_done");
        for (int k = 0; k < 4; k++)
            check("s4_order", (gq.size() > k) ? 32'(gq[k]) : 32'hFFFF_FFFF, 32'(k % 2));
        refill = 0;

        // Slow UART: 50 busy cycles per byte
        do_reset();
        busy_len = 50;
        has_num = 2'b10;
        dc = done_cnt;
        run_until(dc + 1, 3000, "s5_done");

        // Reset in the middle of the byte stream, then a fresh number
        do_reset();
        busy_len = 2;
        has_num = 2'b01;
        n = 0;
        while (rx_cnt < 8 && n < 2000) begin
            step();
            n++;
        end
        check("s6_reach_byte7", 32'(rx_cnt), 32'd8);
        dc = done_cnt;
        do_reset();
        check("s6_no_done", 32'(done_cnt), 32'(dc));
        has_num = 2'b01;
        run_until(dc + 1, 2000, "s6_fresh_done");

        // Random arrivals and UART busy lengths
        do_reset();
        rand_busy = 1;
        rand_arrive = 1;
        has_num = 2'b11;
        dc = done_cnt;
        run_until(dc + 6, 8000, "s7_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
